// File: rtl/dep_issue_sched.sv
// dep_issue_sched: two-requester, dependency-aware issue scheduler.
//
// Each requester offers a key. A key that matches any in-flight slot is held
// off (dependency stall). Otherwise the requesters are arbitrated round-robin,
// the winner is allocated the lowest free slot, and the key/source/tag are
// loaded into a single issue register for downstream. Downstream later
// retires the slot by tag, which frees it for reuse the following cycle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req{0,1}_valid_i/_key_i   requester key offers
//   req{0,1}_ready_o          combinational grant for each requester
//   issue_valid_o/_key_o/_src_o/_tag_o, issue_ready_i
//                             issue register with valid/ready handshake
//   done_valid_i, done_tag_i  slot retire request
//   slot_busy_o               per-slot valid bits
//   dep_stall_o               per-requester dependency stall
//   err_o                     sticky flag for retire of a non-busy slot or tag 3
module dep_issue_sched #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned NUM_SLOTS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid_i,
  input  logic [WIDTH-1:0]     req0_key_i,
  output logic                 req0_ready_o,
  input  logic                 req1_valid_i,
  input  logic [WIDTH-1:0]     req1_key_i,
  output logic                 req1_ready_o,
  output logic                 issue_valid_o,
  output logic [WIDTH-1:0]     issue_key_o,
  output logic                 issue_src_o,
  output logic [1:0]           issue_tag_o,
  input  logic                 issue_ready_i,
  input  logic                 done_valid_i,
  input  logic [1:0]           done_tag_i,
  output logic [NUM_SLOTS-1:0] slot_busy_o,
  output logic [1:0]           dep_stall_o,
  output logic                 err_o
);

  // Slot table
  logic [NUM_SLOTS-1:0] slot_valid_q, slot_valid_d;
  logic [WIDTH-1:0]     slot_key_q [NUM_SLOTS];
  logic [WIDTH-1:0]     slot_key_d [NUM_SLOTS];

  // Issue register
  logic             issue_valid_q, issue_valid_d;
  logic [WIDTH-1:0] issue_key_q, issue_key_d;
  logic             issue_src_q, issue_src_d;
  logic [1:0]       issue_tag_q, issue_tag_d;

  // Arbitration pointer and sticky error
  logic ptr_q, ptr_d;
  logic err_q, err_d;

  // Decode
  logic [1:0]           conflict;
  logic [1:0]           elig;
  logic [1:0]           grant;
  logic                 any_free;
  logic [1:0]           alloc_idx;
  logic [NUM_SLOTS-1:0] retire_hit;
  logic                 retire_err;
  logic                 can_load;
  logic [WIDTH-1:0]     grant_key;

  // Conflict, free-slot and retire decode all look only at the registered
  // table, so a slot retired this cycle still blocks and is still occupied.
  always_comb begin
    conflict   = '0;
    any_free   = 1'b0;
    alloc_idx  = '0;
    retire_hit = '0;
    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
      if (slot_valid_q[s] && (slot_key_q[s] == req0_key_i)) conflict[0] = 1'b1;
      if (slot_valid_q[s] && (slot_key_q[s] == req1_key_i)) conflict[1] = 1'b1;
      if (done_valid_i && (done_tag_i == 2'(s)) && slot_valid_q[s]) retire_hit[s] = 1'b1;
    end
    // Descending scan so the lowest free index is the one left standing.
    for (int s = int'(NUM_SLOTS) - 1; s >= 0; s--) begin
      if (!slot_valid_q[s]) begin
        any_free  = 1'b1;
        alloc_idx = 2'(s);
      end
    end
    conflict[0] = conflict[0] & req0_valid_i;
    conflict[1] = conflict[1] & req1_valid_i;
    retire_err  = done_valid_i & ~(|retire_hit);
  end

  // Round-robin grant
  always_comb begin
    can_load = ~issue_valid_q | issue_ready_i;
    elig[0]  = req0_valid_i & ~conflict[0] & any_free & can_load & ~rst;
    elig[1]  = req1_valid_i & ~conflict[1] & any_free & can_load & ~rst;
    grant    = '0;
    if (elig[ptr_q]) begin
      grant[ptr_q] = 1'b1;
    end else if (elig[~ptr_q]) begin
      grant[~ptr_q] = 1'b1;
    end
    grant_key = grant[1] ? req1_key_i : req0_key_i;
  end

  // Next state
  always_comb begin
    slot_valid_d  = slot_valid_q;
    slot_key_d    = slot_key_q;
    issue_valid_d = issue_valid_q;
    issue_key_d   = issue_key_q;
    issue_src_d   = issue_src_q;
    issue_tag_d   = issue_tag_q;
    ptr_d         = ptr_q;
    err_d         = err_q | retire_err;

    slot_valid_d = slot_valid_d & ~retire_hit;

    if (issue_valid_q && issue_ready_i) begin
      issue_valid_d = 1'b0;
    end

    // Allocation never collides with a retire: the retiring slot is still
    // valid this cycle, so alloc_idx cannot point at it.
    if (|grant) begin
      for (int s = 0; s < int'(NUM_SLOTS); s++) begin
        if (alloc_idx == 2'(s)) begin
          slot_valid_d[s] = 1'b1;
          slot_key_d[s]   = grant_key;
        end
      end
      issue_valid_d = 1'b1;
      issue_key_d   = grant_key;
      issue_src_d   = grant[1];
      issue_tag_d   = alloc_idx;
      ptr_d         = ~grant[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= '0;
      for (int s = 0; s < int'(NUM_SLOTS); s++) begin
        slot_key_q[s] <= '0;
      end
      issue_valid_q <= 1'b0;
      issue_key_q   <= '0;
      issue_src_q   <= 1'b0;
      issue_tag_q   <= '0;
      ptr_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      for (int s = 0; s < int'(NUM_SLOTS); s++) begin
        slot_key_q[s] <= slot_key_d[s];
      end
      issue_valid_q <= issue_valid_d;
      issue_key_q   <= issue_key_d;
      issue_src_q   <= issue_src_d;
      issue_tag_q   <= issue_tag_d;
      ptr_q         <= ptr_d;
      err_q         <= err_d;
    end
  end

  assign req0_ready_o  = grant[0];
  assign req1_ready_o  = grant[1];
  assign issue_valid_o = issue_valid_q;
  assign issue_key_o   = issue_key_q;
  assign issue_src_o   = issue_src_q;
  assign issue_tag_o   = issue_tag_q;
  assign slot_busy_o   = slot_valid_q;
  assign dep_stall_o   = conflict;
  assign err_o         = err_q;

endmodule

// File: tb/tb_dep_issue_sched.sv
// Self-checking bench for dep_issue_sched: a table of one-cycle vectors with
// expected combinational and registered outputs, a scoreboard queue of
// expected issue entries, and a hand-written backpressure sequence.
module tb_dep_issue_sched;

  localparam int unsigned WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid_i, req1_valid_i;
  logic [WIDTH-1:0] req0_key_i, req1_key_i;
  logic             req0_ready_o, req1_ready_o;
  logic             issue_valid_o;
  logic [WIDTH-1:0] issue_key_o;
  logic             issue_src_o;
  logic [1:0]       issue_tag_o;
  logic             issue_ready_i;
  logic             done_valid_i;
  logic [1:0]       done_tag_i;
  logic [2:0]       slot_busy_o;
  logic [1:0]       dep_stall_o;
  logic             err_o;

  always #5 clk = ~clk;

  dep_issue_sched #(.WIDTH(WIDTH), .NUM_SLOTS(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid_i (req0_valid_i),
    .req0_key_i   (req0_key_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_key_i   (req1_key_i),
    .req1_ready_o (req1_ready_o),
    .issue_valid_o(issue_valid_o),
    .issue_key_o  (issue_key_o),
    .issue_src_o  (issue_src_o),
    .issue_tag_o  (issue_tag_o),
    .issue_ready_i(issue_ready_i),
    .done_valid_i (done_valid_i),
    .done_tag_i   (done_tag_i),
    .slot_busy_o  (slot_busy_o),
    .dep_stall_o  (dep_stall_o),
    .err_o        (err_o)
  );

  // One vector = one clock cycle. e_busy/e_iv/e_err are the registered
  // outputs at the start of that cycle; e_rdy/e_stall are combinational.
  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] k0;
    logic       v1;
    logic [7:0] k1;
    logic       ir;
    logic       dv;
    logic [1:0] dt;
    logic [1:0] e_rdy;
    logic [1:0] e_stall;
    logic [2:0] e_busy;
    logic       e_iv;
    logic       e_err;
    logic [1:0] e_tag;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] key;
    logic             src;
    logic [1:0]       tag;
  } iss_t;

  vec_t vecs[26];
  iss_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic r, logic v0, logic [7:0] k0, logic v1, logic [7:0] k1,
                              logic ir, logic dv, logic [1:0] dt, logic [1:0] e_rdy,
                              logic [1:0] e_stall, logic [2:0] e_busy, logic e_iv,
                              logic e_err, logic [1:0] e_tag);
    vec_t v;
    v.rst = r; v.v0 = v0; v.k0 = k0; v.v1 = v1; v.k1 = k1; v.ir = ir; v.dv = dv; v.dt = dt;
    v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_busy = e_busy; v.e_iv = e_iv;
    v.e_err = e_err; v.e_tag = e_tag;
    return v;
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic [7:0] k0, input logic v1,
                       input logic [7:0] k1, input logic ir, input logic dv,
                       input logic [1:0] dt);
    rst = r; req0_valid_i = v0; req0_key_i = WIDTH'(k0);
    req1_valid_i = v1; req1_key_i = WIDTH'(k1);
    issue_ready_i = ir; done_valid_i = dv; done_tag_i = dt;
  endtask

  // Compare the issue register against the oldest outstanding entry.
  task automatic chk_issue(input string tagname);
    if (issue_valid_o === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL %s sb_empty: got issue key 0x%0h, expected no entry", tagname,
                 issue_key_o);
      end else begin
        chk({tagname, " key"}, issue_key_o, sb[0].key);
        chk({tagname, " src"}, WIDTH'(issue_src_o), WIDTH'(sb[0].src));
        chk({tagname, " tag"}, WIDTH'(issue_tag_o), WIDTH'(sb[0].tag));
      end
    end
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 8'h10, 0, 8'h00, 1, 0, 0, 2'b01, 2'b00, 3'b000, 0, 0, 0);
    vecs[1]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 2'b00, 2'b00, 3'b001, 1, 0, 0);
    vecs[2]  = mk(0, 0, 8'h00, 1, 8'h10, 1, 0, 0, 2'b00, 2'b10, 3'b001, 0, 0, 0);
    vecs[3]  = mk(0, 0, 8'h00, 1, 8'h10, 1, 1, 0, 2'b00, 2'b10, 3'b001, 0, 0, 0);
    vecs[4]  = mk(0, 0, 8'h00, 1, 8'h10, 1, 0, 0, 2'b10, 2'b00, 3'b000, 0, 0, 0);
    vecs[5]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 2'b00, 2'b00, 3'b001, 1, 0, 0);
    vecs[6]  = mk(0, 1, 8'h20, 1, 8'h21, 1, 0, 0, 2'b01, 2'b00, 3'b000, 0, 0, 0);
    vecs[7]  = mk(0, 1, 8'h22, 1, 8'h21, 1, 0, 0, 2'b10, 2'b00, 3'b001, 1, 0, 1);
    vecs[8]  = mk(0, 1, 8'h22, 1, 8'h23, 1, 0, 0, 2'b01, 2'b00, 3'b011, 1, 0, 2);
    vecs[9]  = mk(0, 1, 8'h24, 1, 8'h23, 1, 0, 0, 2'b00, 2'b00, 3'b111, 1, 0, 0);
    vecs[10] = mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 2'b00, 2'b00, 3'b111, 0, 0, 0);
    vecs[11] = mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 1, 2'b00, 2'b00, 3'b110, 0, 0, 0);
    vecs[12] = mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 2, 2'b00, 2'b00, 3'b100, 0, 0, 0);
    vecs[13] = mk(0, 1, 8'h30, 1, 8'h30, 1, 0, 0, 2'b10, 2'b00, 3'b000, 0, 0, 0);
    vecs[14] = mk(0, 1, 8'h30, 0, 8'h00, 0, 0, 0, 2'b00, 2'b01, 3'b001, 1, 0, 0);
    vecs[15] = mk(0, 1, 8'h31, 0, 8'h00, 0, 0, 0, 2'b00, 2'b00, 3'b001, 1, 0, 0);
    vecs[16] = mk(0, 1, 8'h31, 0, 8'h00, 1, 0, 0, 2'b01, 2'b00, 3'b001, 1, 0, 1);
    vecs[17] = mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 3, 2'b00, 2'b00, 3'b011, 1, 0, 0);
    vecs[18] = mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 2, 2'b00, 2'b00, 3'b011, 1, 1, 0);
    vecs[19] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 2'b00, 2'b00, 3'b011, 1, 1, 0);
    vecs[20] = mk(1, 1, 8'h40, 0, 8'h00, 0, 0, 0, 2'b00, 2'b00, 3'b011, 1, 1, 0);
    vecs[21] = mk(0, 1, 8'h11, 1, 8'h12, 1, 0, 0, 2'b01, 2'b00, 3'b000, 0, 0, 0);
    vecs[22] = mk(0, 0, 8'h00, 1, 8'h12, 1, 1, 0, 2'b10, 2'b00, 3'b001, 1, 0, 1);
    vecs[23] = mk(0, 1, 8'h11, 0, 8'h00, 1, 0, 0, 2'b01, 2'b00, 3'b010, 1, 0, 0);
    vecs[24] = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 2'b00, 2'b00, 3'b011, 1, 0, 0);
    vecs[25] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 2'b00, 2'b00, 3'b011, 0, 0, 0);

    // Initial reset; grants must stay low while rst is high.
    drive(1, 1, 8'h55, 1, 8'h66, 1, 0, 0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #4;
      chk("rst_ready", WIDTH'({req1_ready_o, req0_ready_o}), '0);
    end
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    #3;
    chk("rst_busy", WIDTH'(slot_busy_o), '0);
    chk("rst_iv", WIDTH'(issue_valid_o), '0);
    chk("rst_key", issue_key_o, '0);
    chk("rst_src", WIDTH'(issue_src_o), '0);
    chk("rst_tag", WIDTH'(issue_tag_o), '0);
    chk("rst_err", WIDTH'(err_o), '0);

    for (int i = 0; i < 26; i++) begin
      string nm;
      iss_t  e;
      nm = $sformatf("v%0d", i);
      @(posedge clk); #1;
      drive(vecs[i].rst, vecs[i].v0, vecs[i].k0, vecs[i].v1, vecs[i].k1, vecs[i].ir,
            vecs[i].dv, vecs[i].dt);
      #3;
      chk({nm, " ready"}, WIDTH'({req1_ready_o, req0_ready_o}), WIDTH'(vecs[i].e_rdy));
      chk({nm, " stall"}, WIDTH'(dep_stall_o), WIDTH'(vecs[i].e_stall));
      chk({nm, " busy"}, WIDTH'(slot_busy_o), WIDTH'(vecs[i].e_busy));
      chk({nm, " iv"}, WIDTH'(issue_valid_o), WIDTH'(vecs[i].e_iv));
      chk({nm, " err"}, WIDTH'(err_o), WIDTH'(vecs[i].e_err));
      chk_issue(nm);
      if (issue_valid_o === 1'b1 && vecs[i].ir && sb.size() > 0) void'(sb.pop_front());
      if (vecs[i].e_rdy != 2'b00) begin
        e.src = vecs[i].e_rdy[1];
        e.key = e.src ? WIDTH'(vecs[i].k1) : WIDTH'(vecs[i].k0);
        e.tag = vecs[i].e_tag;
        sb.push_back(e);
      end
      if (vecs[i].rst) sb.delete();
    end

    // Hand sequence: long backpressure with the table full; the issue entry
    // must hold steady and nothing else may be granted.
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 1, 8'h50, 0, 0, 0);
    #3;
    chk("bp grant", WIDTH'({req1_ready_o, req0_ready_o}), WIDTH'(2'b10));
    begin
      iss_t e;
      e.key = WIDTH'(8'h50); e.src = 1'b1; e.tag = 2'd2;
      sb.push_back(e);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      drive(0, 1, 8'h51, 0, 8'h00, 0, 0, 0);
      #3;
      chk("bp ready", WIDTH'({req1_ready_o, req0_ready_o}), '0);
      chk("bp iv", WIDTH'(issue_valid_o), WIDTH'(1'b1));
      chk("bp busy", WIDTH'(slot_busy_o), WIDTH'(3'b111));
      chk_issue("bp");
    end
    @(posedge clk); #1;
    drive(0, 1, 8'h51, 0, 8'h00, 1, 0, 0);
    #3;
    chk("bp full ready", WIDTH'({req1_ready_o, req0_ready_o}), '0);
    chk_issue("bp last");
    if (issue_valid_o === 1'b1 && sb.size() > 0) void'(sb.pop_front());
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    #3;
    chk("bp drop iv", WIDTH'(issue_valid_o), '0);
    chk("sb drained", WIDTH'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dep_issue_sched.md
DEP_ISSUE_SCHED -- requirements
Module: dep_issue_sched

Interface
REQ-001 Parameter: WIDTH, default 64, key width in bits.
REQ-002 Parameter: NUM_SLOTS, fixed at 3, number of in-flight tracking slots (slot tags 0..2).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req0_valid_i  in  1  requester 0 has a key
- req0_key_i  in  WIDTH  requester 0 key
- req0_ready_o  out  1  requester 0 accepted this cycle
- req1_valid_i  in  1  requester 1 has a key
- req1_key_i  in  WIDTH  requester 1 key
- req1_ready_o  out  1  requester 1 accepted this cycle
- issue_valid_o  out  1  issue register holds an entry
- issue_key_o  out  WIDTH  issued key
- issue_src_o  out  1  requester index of issued entry
- issue_tag_o  out  2  slot tag of issued entry
- issue_ready_i  in  1  downstream consumes issue entry
- done_valid_i  in  1  downstream retires a slot
- done_tag_i  in  2  slot tag being retired
- slot_busy_o  out  3  per-slot valid bits
- dep_stall_o  out  2  per-requester dependency stall indicator
- err_o  out  1  sticky illegal-retire flag

Function
REQ-004 The block SHALL keep a slot table of 3 entries, each holding a valid bit and a WIDTH-bit key; slot_busy_o SHALL equal the registered valid bits.
REQ-005 A requester is in conflict when its valid is high and its key equals the key of any valid slot. Comparison SHALL use only the registered table state from the start of the cycle.
REQ-006 dep_stall_o[r] SHALL be high exactly when requester r is in conflict.
REQ-007 A requester SHALL be eligible when all of the following hold: its valid is high, it is not in conflict, at least one slot is free, and the issue register can load.
REQ-008 The issue register can load when issue_valid_o is low, or when issue_valid_o and issue_ready_i are both high in the same cycle.
REQ-009 Arbitration SHALL be round-robin with a 1-bit priority pointer:
- the pointed-to requester wins if eligible; otherwise the other requester wins if eligible;
- after any grant, the pointer SHALL move to the non-granted requester;
- the pointer SHALL NOT change when there is no grant.
REQ-010 At most one grant SHALL occur per cycle; req{r}_ready_o SHALL be the combinational grant for requester r.
REQ-011 On a grant in cycle N, the block SHALL:
- allocate the lowest-index free slot, setting its valid bit and storing the key;
- load the issue register with key, src and tag;
- assert issue_valid_o from cycle N+1 (one-cycle latency).
REQ-012 issue_valid_o SHALL drop after an issue_ready_i handshake unless a new grant reloads the register in the same cycle. Issue outputs SHALL hold stable while issue_valid_o is high and issue_ready_i is low.
REQ-013 Retire: when done_valid_i is high and done_tag_i addresses a valid slot (0..2), that slot's valid bit SHALL clear at the next edge.
REQ-014 A freed slot SHALL NOT be allocatable, and SHALL NOT unblock a conflict, until the cycle after the retire.
REQ-015 A retire of an invalid slot, or of tag 3, SHALL set err_o and leave the table unchanged. err_o SHALL clear only on reset.
REQ-016 If both requesters present the same key in the same cycle with no conflict, only the arbitration winner is granted; the loser SHALL see the new slot as a conflict in the following cycle.
REQ-017 A retire and an allocation in the same cycle SHALL both take effect. The allocation SHALL NOT target the slot being retired, because that slot still reads as valid this cycle.
REQ-018 With all 3 slots valid, no grant SHALL occur regardless of the requests.

Reset
REQ-019 While rst is high at a clock edge, the block SHALL:
- clear all slot valid bits and set all slot keys to 0;
- clear the issue register: issue_valid_o=0, issue_key_o=0, issue_src_o=0, issue_tag_o=0;
- set the priority pointer to 0 and clear err_o.
REQ-020 During a reset cycle, req0_ready_o and req1_ready_o SHALL be 0. A reset asserted mid-operation SHALL discard all in-flight and issued entries without any retire.

Verification
REQ-021 Single issue: req0 key 0x10 with issue_ready_i=1 -> req0_ready_o=1 at N; at N+1 issue_valid_o=1, key 0x10, src 0, tag 0, slot_busy_o=3'b001.
REQ-022 Dependency block: slot holds 0x10, req1 presents 0x10 -> dep_stall_o=2'b10, no grant. Retire tag 0 at M -> grant no earlier than M+1.
REQ-023 Round-robin: both requesters valid with distinct keys every cycle, no retires, issue_ready_i=1 -> grants alternate 0,1,0 into tags 0,1,2; the fourth request stalls with slot_busy_o=3'b111.
REQ-024 Same key in both requesters, pointer=1 -> req1 granted; next cycle dep_stall_o[0]=1 and req0 not granted.
REQ-025 Backpressure and retire: issue_ready_i=0 with issue_valid_o=1 -> outputs stable, no new grant. done_tag_i=3 -> err_o=1, sticky until rst.
REQ-026 Mid-operation reset: rst=1 with 2 slots busy and issue_valid_o=1 -> next cycle slot_busy_o=0, issue_valid_o=0, err_o=0.
